// File: rtl/tt_um_toivoh_serial_alu.sv
// Byte-serial operand loader feeding a digit-serial ALU.
// Operands are written one byte at a time through ui_in, the ALU walks the
// operands DIGIT_BITS bits per cycle, and the result is read back byte-wise.
module tt_um_toivoh_serial_alu #(
    parameter int LOG2_BYTES_IN = 3,
    parameter int DIGIT_BITS    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] uo_out
);

    localparam int BYTES_IN = 1 << LOG2_BYTES_IN;
    localparam int W        = BYTES_IN * 4;          // bits per operand
    localparam int N        = W / DIGIT_BITS;        // ALU cycles per operation
    localparam int KW       = (N > 1) ? $clog2(N) : 1;
    localparam int WPW      = (LOG2_BYTES_IN > 0) ? LOG2_BYTES_IN : 1;
    localparam int RPW      = (LOG2_BYTES_IN > 1) ? LOG2_BYTES_IN - 1 : 1;

    localparam logic [KW-1:0]  K_LAST = KW'(N - 1);
    localparam logic [RPW-1:0] R_LAST = RPW'(BYTES_IN / 2 - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // One digit of the ALU: low DIGIT_BITS are the result digit, top bit is
    // the carry out. Logic ops never produce a carry.
    function automatic logic [DIGIT_BITS:0] alu_digit(
        input logic [1:0]            op,
        input logic [DIGIT_BITS-1:0] a,
        input logic [DIGIT_BITS-1:0] b,
        input logic                  cin
    );
        logic [DIGIT_BITS:0] r;
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b} + {{DIGIT_BITS{1'b0}}, cin};
            OP_SUB:  r = {1'b0, a} + {1'b0, ~b} + {{DIGIT_BITS{1'b0}}, cin};
            OP_AND:  r = {1'b0, a & b};
            default: r = {1'b0, a ^ b};
        endcase
        return r;
    endfunction

    // Strobe history and edge events
    logic wr_q, rd_q, start_q;
    logic wr_ev, rd_ev, start_ev, clr_ptr;

    // Storage and pointers
    logic [2*W-1:0] opnd_q;
    logic [W-1:0]   result_q;
    logic [WPW-1:0] wptr_q, wptr_d;
    logic [RPW-1:0] rptr_q, rptr_d;

    // ALU control
    state_t        state_q;
    logic [1:0]    op_q;
    logic [KW-1:0] k_q;
    logic          carry_q;
    logic          busy_q;
    logic          done_q;

    logic [DIGIT_BITS-1:0] x_dig, y_dig;
    logic [DIGIT_BITS:0]   dig_res;
    logic                  wr_ok;

    assign wr_ev    = uio_in[0] & ~wr_q;
    assign rd_ev    = uio_in[1] & ~rd_q;
    assign start_ev = uio_in[2] & ~start_q;
    assign clr_ptr  = uio_in[5];
    assign wr_ok    = wr_ev && (state_q != S_RUN);

    // Remember last strobe levels; reset to 1 so a strobe held across reset release is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b1;
            rd_q    <= 1'b1;
            start_q <= 1'b1;
        end else begin
            wr_q    <= uio_in[0];
            rd_q    <= uio_in[1];
            start_q <= uio_in[2];
        end
    end

    // Next pointer values; clr_ptr overrides any increment
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_ev) begin
            rptr_d = (rptr_q == R_LAST) ? '0 : rptr_q + 1'b1;
        end
        if (clr_ptr) begin
            wptr_d = '0;
            rptr_d = '0;
        end
    end

    // Operand byte writes (at the old write pointer) and pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_ok) begin
                opnd_q[wptr_q*8 +: 8] <= ui_in;
            end
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    assign x_dig   = opnd_q[k_q*DIGIT_BITS +: DIGIT_BITS];
    assign y_dig   = opnd_q[W + k_q*DIGIT_BITS +: DIGIT_BITS];
    assign dig_res = alu_digit(op_q, x_dig, y_dig, carry_q);

    // ALU sequencer: IDLE/DONE wait for start, RUN processes one digit per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            k_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_ev) begin
                        state_q <= S_RUN;
                        op_q    <= uio_in[4:3];
                        k_q     <= '0;
                        carry_q <= (uio_in[4:3] == OP_SUB);
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    result_q[k_q*DIGIT_BITS +: DIGIT_BITS] <= dig_res[DIGIT_BITS-1:0];
                    carry_q <= dig_res[DIGIT_BITS];
                    k_q     <= k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign uo_out  = result_q[rptr_q*8 +: 8];
    assign uio_out = {done_q, busy_q, carry_q, 5'b0_0000};
    assign uio_oe  = 8'b1110_0000;

    // ena and the spare uio bits carry no function
    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in[7:6]};

endmodule

// File: tb/tb_tt_um_toivoh_serial_alu.sv
// Self-checking bench for tt_um_toivoh_serial_alu (default parameters: W=32, N=8).
module tb_tt_um_toivoh_serial_alu;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b1;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;
    wire  [7:0] uo_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tt_um_toivoh_serial_alu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .uo_out  (uo_out)
    );

    // Reference: {carry, result} straight from the arithmetic definition of each op
    function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            2'd0:    return {1'b0, x} + {1'b0, y};
            2'd1:    return {(x >= y), x - y};
            2'd2:    return {1'b0, x & y};
            default: return {1'b0, x ^ y};
        endcase
    endfunction

    task automatic pulse(input int idx);
        @(negedge clk); uio_in[idx] = 1'b1;
        @(negedge clk); uio_in[idx] = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk); ui_in = b; uio_in[0] = 1'b1;
        @(negedge clk); uio_in[0] = 1'b0;
    endtask

    task automatic load(input logic [31:0] x, input logic [31:0] y, input bit do_clr);
        if (do_clr) pulse(5);
        for (int i = 0; i < 4; i++) write_byte(x[i*8 +: 8]);
        for (int i = 0; i < 4; i++) write_byte(y[i*8 +: 8]);
    endtask

    task automatic start_op(input logic [1:0] op);
        @(negedge clk); uio_in[4:3] = op; uio_in[2] = 1'b1;
        @(negedge clk); uio_in[2] = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (uio_out[6] && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    // Reads 4 bytes starting at the current read pointer; leaves rptr wrapped back to its start
    task automatic read_result(output logic [31:0] r);
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = uo_out;
            pulse(1);
        end
    endtask

    task automatic exec(input logic [1:0] op, output logic [31:0] res, output logic c,
                        output logic d, output int cyc);
        start_op(op);
        wait_done(cyc);
        d = uio_out[7];
        c = uio_out[5];
        read_result(res);
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        uio_in = 8'h07;
        ui_in  = 8'hAA;
        repeat (3) @(negedge clk);
        checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo_out got %h want 00", uo_out); end
        checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_uio_out got %h want 00", uio_out); end
        checks++; if (uio_oe !== 8'hE0) begin errors++; $display("FAIL reset_uio_oe got %h want e0", uio_oe); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL release_uio_out got %h want 00", uio_out); end
        checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL release_uo_out got %h want 00", uo_out); end
        uio_in = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_add;
        logic [31:0] res; logic c, d; int cyc;
        logic [32:0] exp;
        exp = model(2'd0, 32'hFFFFFFFF, 32'h00000001);
        load(32'hFFFFFFFF, 32'h00000001, 1'b0);   // no clr: wptr must still be 0 after reset
        exec(2'd0, res, c, d, cyc);
        checks++; if (cyc !== 8) begin errors++; $display("FAIL add_busy_cycles got %0d want 8", cyc); end
        checks++; if (d !== 1'b1) begin errors++; $display("FAIL add_done got %b want 1", d); end
        checks++; if (c !== exp[32]) begin errors++; $display("FAIL add_carry got %b want %b", c, exp[32]); end
        checks++; if (res !== exp[31:0]) begin errors++; $display("FAIL add_result got %h want %h", res, exp[31:0]); end
        checks++; if (uo_out !== exp[7:0]) begin errors++; $display("FAIL add_rptr_wrap got %h want %h", uo_out, exp[7:0]); end
    endtask

    task automatic test_sub;
        logic [31:0] res; logic c, d; int cyc;
        logic [32:0] exp;
        exp = model(2'd1, 32'd5, 32'd7);
        load(32'd5, 32'd7, 1'b1);
        exec(2'd1, res, c, d, cyc);
        checks++; if (res !== 32'hFFFFFFFE || res !== exp[31:0]) begin errors++; $display("FAIL sub_lt_result got %h want fffffffe", res); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL sub_lt_carry got %b want 0", c); end
        exp = model(2'd1, 32'd7, 32'd5);
        load(32'd7, 32'd5, 1'b1);
        exec(2'd1, res, c, d, cyc);
        checks++; if (res !== exp[31:0]) begin errors++; $display("FAIL sub_gt_result got %h want %h", res, exp[31:0]); end
        checks++; if (c !== 1'b1) begin errors++; $display("FAIL sub_gt_carry got %b want 1", c); end
        checks++; if (cyc !== 8) begin errors++; $display("FAIL sub_busy_cycles got %0d want 8", cyc); end
    endtask

    task automatic test_logic;
        logic [31:0] res; logic c, d; int cyc;
        load(32'h12345678, 32'h0F0F0F0F, 1'b1);
        exec(2'd2, res, c, d, cyc);
        checks++; if (res !== 32'h02040608) begin errors++; $display("FAIL and_result got %h want 02040608", res); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL and_carry got %b want 0", c); end
        exec(2'd3, res, c, d, cyc);          // restart straight from DONE
        checks++; if (res !== 32'h1D3B5977) begin errors++; $display("FAIL xor_result got %h want 1d3b5977", res); end
        checks++; if (d !== 1'b1 || cyc !== 8) begin errors++; $display("FAIL xor_restart got done=%b cycles=%0d want 1/8", d, cyc); end
    endtask

    task automatic test_run_ignore;
        logic [31:0] res; logic c; int cyc;
        logic [32:0] exp;
        load(32'h12345678, 32'h0F0F0F0F, 1'b1);
        start_op(2'd0);
        write_byte(8'hAA);                   // dropped while running
        pulse(2);                            // ignored while running
        wait_done(cyc);
        checks++; if (cyc + 4 !== 8) begin errors++; $display("FAIL run_busy_total got %0d want 8", cyc + 4); end
        c = uio_out[5];
        read_result(res);
        exp = model(2'd0, 32'h12345678, 32'h0F0F0F0F);
        checks++; if (res !== exp[31:0] || c !== exp[32]) begin errors++; $display("FAIL run_operands got %h/%b want %h/%b", res, c, exp[31:0], exp[32]); end
        // wptr must still be 0: this byte replaces x[7:0]
        write_byte(8'h55);
        start_op(2'd0);
        wait_done(cyc);
        read_result(res);
        exp = model(2'd0, 32'h12345655, 32'h0F0F0F0F);
        checks++; if (res !== exp[31:0]) begin errors++; $display("FAIL run_wptr got %h want %h", res, exp[31:0]); end
        pulse(1);
        checks++; if (uo_out !== exp[15:8]) begin errors++; $display("FAIL rd_step got %h want %h", uo_out, exp[15:8]); end
        @(negedge clk); uio_in[1] = 1'b1; uio_in[5] = 1'b1;
        @(negedge clk); uio_in[1] = 1'b0; uio_in[5] = 1'b0;
        checks++; if (uo_out !== exp[7:0]) begin errors++; $display("FAIL clr_over_rd got %h want %h", uo_out, exp[7:0]); end
    endtask

    task automatic test_reset_mid_run;
        logic [31:0] res; logic c, d; int cyc;
        load(32'h01020304, 32'h10203040, 1'b1);
        start_op(2'd0);
        repeat (3) @(negedge clk);           // k = 3
        rst_n = 1'b0;
        #1;
        checks++; if (uio_out[7:6] !== 2'b00) begin errors++; $display("FAIL midrst_status got %b want 00", uio_out[7:6]); end
        checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL midrst_uo_out got %h want 00", uo_out); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL midrst_idle got %h want 00", uio_out); end
        // operands were cleared; a SUB of 0-0 from IDLE gives 0 with no borrow
        exec(2'd1, res, c, d, cyc);
        checks++; if (res !== 32'h0 || c !== 1'b1 || cyc !== 8) begin errors++; $display("FAIL midrst_restart got %h/%b/%0d want 0/1/8", res, c, cyc); end
    endtask

    task automatic test_random;
        logic [31:0] x, y, res; logic c, d; int cyc;
        logic [1:0] op;
        logic [32:0] exp;
        for (int i = 0; i < 12; i++) begin
            x  = $urandom;
            y  = (i == 0) ? x : $urandom;
            op = 2'($urandom_range(0, 3));
            if (i < 4) op = 2'(i);
            exp = model(op, x, y);
            load(x, y, 1'b1);
            exec(op, res, c, d, cyc);
            checks++;
            if (res !== exp[31:0] || c !== exp[32] || d !== 1'b1 || cyc !== 8) begin
                errors++;
                $display("FAIL rand_%0d op=%0d x=%h y=%h got %h/%b/%b/%0d want %h/%b/1/8",
                         i, op, x, y, res, c, d, cyc, exp[31:0], exp[32]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_run_ignore();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
